// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - queues ALU commands, issues them one at a time, returns responses
module alu_cmd_issuer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int LAT_FIX = 3,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [4:0]       rsp_op,
  output logic             rsp_error,
  output logic             rsp_timeout,
  output logic             start_alu,
  output logic [4:0]       op,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic             busy_alu,
  input  logic             valid_alu,
  input  logic             error_alu,
  input  logic [WIDTH-1:0] result
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (TIMEOUT > LAT_FIX) ? TIMEOUT : LAT_FIX;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [4:0]        mem_op [DEPTH];
  logic [WIDTH-1:0]  mem_a  [DEPTH];
  logic [WIDTH-1:0]  mem_b  [DEPTH];
  logic              full, empty, push, pop, done, forced, multi;
  logic [WIDTH-1:0]  rsp_data_q;
  logic [4:0]        rsp_op_q;
  logic              rsp_error_q, rsp_timeout_q;

  // The extra pointer bit differs only when the writer has lapped the reader.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign multi     = (op_q inside {5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01110});

  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr_q[AW-1:0]] <= cmd_op;
      mem_a[wr_ptr_q[AW-1:0]]  <= cmd_a;
      mem_b[wr_ptr_q[AW-1:0]]  <= cmd_b;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    pop     = 1'b0;
    done    = 1'b0;
    forced  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !busy_alu) begin
          state_d = S_ISSUE;
          op_d    = mem_op[rd_ptr_q[AW-1:0]];
          a_d     = mem_a[rd_ptr_q[AW-1:0]];
          b_d     = mem_b[rd_ptr_q[AW-1:0]];
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (multi ? valid_alu : (cnt_q == CW'(LAT_FIX))) begin
          done = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          done   = 1'b1;
          forced = 1'b1;
        end
        if (done) begin
          pop     = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rsp_data_q    <= '0;
      rsp_op_q      <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (done) begin
        rsp_data_q    <= forced ? '0 : result;
        rsp_op_q      <= op_q;
        rsp_error_q   <= forced ? 1'b0 : error_alu;
        rsp_timeout_q <= forced;
      end
    end
  end

  assign start_alu   = (state_q == S_ISSUE);
  assign rsp_valid   = (state_q == S_RESP);
  assign op          = op_q;
  assign A           = a_q;
  assign B           = b_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - scoreboard bench for alu_cmd_issuer with a scripted ALU model
module tb_alu_cmd_issuer;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int LAT_FIX = 3;
  localparam int TIMEOUT = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [4:0]       cmd_op = '0;
  logic [WIDTH-1:0] cmd_a = '0, cmd_b = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] rsp_data;
  logic [4:0]       rsp_op;
  logic             rsp_error, rsp_timeout;
  logic             start_alu;
  logic [4:0]       op;
  logic [WIDTH-1:0] A, B;
  logic             busy_alu = 1'b0;
  logic             valid_alu = 1'b0;
  logic             error_alu = 1'b0;
  logic [WIDTH-1:0] result = '0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LAT_FIX(LAT_FIX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_op(rsp_op),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .start_alu(start_alu), .op(op), .A(A), .B(B),
    .busy_alu(busy_alu), .valid_alu(valid_alu), .error_alu(error_alu), .result(result)
  );

  typedef struct { logic [4:0] op; logic [WIDTH-1:0] data; logic err; logic tmo; int lat; } exp_t;
  typedef struct { logic [WIDTH-1:0] res; logic err; int delay; } plan_t;
  typedef struct { logic [4:0] op; logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; } iss_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  iss_t  iss_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int last_start = 0;
  bit seen = 0;
  bit prev_start = 0;
  logic [WIDTH-1:0] hold_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ALU model: latches the scripted result on each start, pulses valid_alu after delay cycles
  initial begin
    int cd;
    plan_t p;
    cd = 0;
    forever begin
      @(negedge clk);
      valid_alu = 1'b0;
      if (!rst && start_alu) begin
        if (plan_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL alu_plan actual=start required=no_start");
        end else begin
          p = plan_q.pop_front();
          result    = p.res;
          error_alu = p.err;
          cd        = p.delay;
        end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) valid_alu = 1'b1;
      end
    end
  end

  // Monitor: checks issued operands and each new response against the scoreboard
  initial begin
    exp_t e;
    iss_t s;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        seen = 0;
        prev_start = 0;
      end else begin
        if (start_alu) begin
          chk("start_width", 64'(prev_start), 64'd0);
          starts++;
          last_start = cyc;
          if (iss_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_issue actual=%0h required=none", op);
          end else begin
            s = iss_q.pop_front();
            chk("issue_op", 64'(op), 64'(s.op));
            chk("issue_a", 64'(A), 64'(s.a));
            chk("issue_b", 64'(B), 64'(s.b));
          end
        end
        prev_start = start_alu;
        if (rsp_valid && !seen) begin
          seen = 1;
          hold_data = rsp_data;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp actual=%0h required=none", rsp_data);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_data", 64'(rsp_data), 64'(e.data));
            chk("rsp_op", 64'(rsp_op), 64'(e.op));
            chk("rsp_error", 64'(rsp_error), 64'(e.err));
            chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
            chk("rsp_latency", 64'(cyc - last_start), 64'(e.lat));
          end
        end else if (rsp_valid) begin
          chk("rsp_hold", 64'(rsp_data), 64'(hold_data));
        end else begin
          seen = 0;
        end
      end
    end
  end

  task automatic send(input logic [4:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] res, input logic err, input int dly,
                      input logic [WIDTH-1:0] ed, input logic ee, input logic et, input int lat,
                      input bit want);
    int n;
    plan_q.push_back('{res: res, err: err, delay: dly});
    iss_q.push_back('{op: o, a: a, b: b});
    if (want) exp_q.push_back('{op: o, data: ed, err: ee, tmo: et, lat: lat});
    cmd_op = o; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL push_timeout actual=%0d required=<100", n);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget, input int exp_starts);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=<%0d", n, budget);
    end
    chk("start_count", 64'(starts), 64'(exp_starts));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=%0d required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_start", 64'(start_alu), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);

    send(5'b00110, 5, 7, 12, 1'b0, 0, 12, 1'b0, 1'b0, LAT_FIX + 2, 1);
    drain(50, 1);
    // a fixed-latency op must ignore an early valid_alu
    send(5'b00001, 8, 2, 10, 1'b0, 1, 10, 1'b0, 1'b0, LAT_FIX + 2, 1);
    drain(50, 2);
    send(5'b01010, 100, 7, 14, 1'b0, 34, 14, 1'b0, 1'b0, 35, 1);
    drain(100, 3);
    send(5'b01010, 9, 0, 0, 1'b1, 6, 0, 1'b1, 1'b0, 7, 1);
    drain(50, 4);
    send(5'b01001, 1, 2, 32'hDEAD_BEEF, 1'b0, 0, 0, 1'b0, 1'b1, TIMEOUT + 2, 1);
    drain(600, 5);

    busy_alu = 1'b1;
    send(5'b00110, 3, 4, 7, 1'b0, 0, 7, 1'b0, 1'b0, LAT_FIX + 2, 1);
    repeat (8) @(negedge clk);
    chk("busy_hold", 64'(starts), 64'd5);
    busy_alu = 1'b0;
    drain(50, 6);

    rsp_ready = 1'b0;
    send(5'b00010, 1, 1, 32'h101, 1'b0, 0, 32'h101, 1'b0, 1'b0, LAT_FIX + 2, 1);
    send(5'b00011, 2, 2, 32'h202, 1'b0, 0, 32'h202, 1'b0, 1'b0, LAT_FIX + 2, 1);
    send(5'b00100, 3, 3, 32'h303, 1'b0, 0, 32'h303, 1'b0, 1'b0, LAT_FIX + 2, 1);
    send(5'b00101, 4, 4, 32'h404, 1'b0, 0, 32'h404, 1'b0, 1'b0, LAT_FIX + 2, 1);
    chk("full_cmd_ready", 64'(cmd_ready), 64'd0);
    send(5'b00111, 5, 5, 32'h505, 1'b0, 0, 32'h505, 1'b0, 1'b0, LAT_FIX + 2, 1);
    repeat (3) @(negedge clk);
    rsp_ready = 1'b1;
    drain(200, 11);

    send(5'b01110, 32'h11, 32'h22, 32'h77, 1'b0, 30, 0, 1'b0, 1'b0, 0, 0);
    n = 0;
    while (starts < 12 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_start", 64'(start_alu), 64'd0);
    chk("rst_op", 64'(op), 64'd0);
    chk("rst_a", 64'(A), 64'd0);
    chk("rst_b", 64'(B), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_op", 64'(rsp_op), 64'd0);
    chk("rst_rsp_error", 64'(rsp_error), 64'd0);
    chk("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_starts", 64'(starts), 64'd12);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
